// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the memory write-back block: FSM state encodings
// and the segment shift used to form 20-bit linear addresses.
package mem_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int SEG_SHIFT = 4;
  localparam int ADDR_W    = 20;

endpackage

// File: rtl/mem_writeback_if.sv
// Request and memory-write bus of the write-back block.
// master: the requester (drives start/operands, observes the write bus).
// slave:  the write-back block itself.
interface mem_writeback_if;

  logic        start;
  logic        bit16;
  logic [15:0] seg;
  logic [15:0] eff;
  logic [15:0] result;
  logic [19:0] address;
  logic [7:0]  out;
  logic        wren;
  logic        busy;
  logic        done;

  modport master (
    output start, bit16, seg, eff, result,
    input  address, out, wren, busy, done
  );

  modport slave (
    input  start, bit16, seg, eff, result,
    output address, out, wren, busy, done
  );

endinterface

// File: rtl/mem_writeback_linaddr.sv
// Segment:offset to linear address. Carry out of bit 19 is dropped so the
// address space wraps at 1 MiB.
module linaddr
  import mem_writeback_pkg::*;
(
  input  logic [15:0]       seg,
  input  logic [15:0]       off,
  output logic [ADDR_W-1:0] lin
);

  assign lin = ({4'b0, seg} << SEG_SHIFT) + {4'b0, off};

endmodule

// File: rtl/mem_writeback.sv
// Memory write-back: writes a byte or a little-endian word to seg:eff,
// one byte per cycle, then pulses done. All outputs are registered.
//
// Build option: MEM_WRITEBACK_LINEAR_HI_EN
//   undefined - high byte goes to seg:(eff+1), offset wraps inside the segment
//   defined   - high byte goes to the low-byte linear address + 1
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// WR_LO | low byte on the bus
// WR_HI | high byte on the bus (word writes only)
// FIN   | done pulse; start is ignored here
module mem_writeback
  import mem_writeback_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  mem_writeback_if.slave   bus
);

  state_t      state, state_d;
  logic [15:0] seg_q, eff_q;
  logic [7:0]  result_hi_q;
  logic        bit16_q;

  logic [15:0]       seg_src, off_src;
  logic [ADDR_W-1:0] lin;

  logic [ADDR_W-1:0] address_d, address_q;
  logic [7:0]        out_d, out_q;
  logic              wren_d, wren_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;

  // One adder serves both bytes: operands come straight from the bus while
  // idle, and from the latched request once the transfer is running.
  linaddr u_linaddr (
    .seg (seg_src),
    .off (off_src),
    .lin (lin)
  );

  // Next state and the output values that become visible after the edge.
  always_comb begin
    state_d   = state;
    seg_src   = seg_q;
    off_src   = eff_q;
    address_d = '0;
    out_d     = '0;
    wren_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        seg_src = bus.seg;
        off_src = bus.eff;
        if (bus.start) begin
          state_d   = WR_LO;
          wren_d    = 1'b1;
          busy_d    = 1'b1;
          address_d = lin;
          out_d     = bus.result[7:0];
        end
      end
      WR_LO: begin
`ifdef MEM_WRITEBACK_LINEAR_HI_EN
        off_src = eff_q;
`else
        off_src = eff_q + 16'd1;
`endif
        if (bit16_q) begin
          state_d = WR_HI;
          wren_d  = 1'b1;
          busy_d  = 1'b1;
`ifdef MEM_WRITEBACK_LINEAR_HI_EN
          address_d = lin + 20'd1;
`else
          address_d = lin;
`endif
          out_d = result_hi_q;
        end else begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      WR_HI: begin
        state_d = FIN;
        done_d  = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Capture the request operands on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q       <= '0;
      eff_q       <= '0;
      result_hi_q <= '0;
      bit16_q     <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      seg_q       <= bus.seg;
      eff_q       <= bus.eff;
      result_hi_q <= bus.result[15:8];
      bit16_q     <= bus.bit16;
    end
  end

  // Output registers; reset mid-transfer drops any remaining byte and done.
  always_ff @(posedge clock) begin
    if (reset) begin
      address_q <= '0;
      out_q     <= '0;
      wren_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      address_q <= address_d;
      out_q     <= out_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.address = address_q;
  assign bus.out     = out_q;
  assign bus.wren    = wren_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: each accepted start pushes the expected
// byte writes and done pulse (with the cycle they must appear in); a monitor
// pops and compares them every cycle, #1 after the rising edge.
module tb_mem_writeback;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mem_writeback_if bus ();

  mem_writeback dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [19:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];

  int cyc       = 0;
  int idle_from = 0;
  int n_checks  = 0;
  int n_pass    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [19:0] lo_addr(input logic [15:0] s, input logic [15:0] e);
    return {s, 4'h0} + {4'h0, e};
  endfunction

  function automatic logic [19:0] hi_addr(input logic [15:0] s, input logic [15:0] e);
    logic [15:0] e1;
    e1 = e + 16'd1;
`ifdef MEM_WRITEBACK_LINEAR_HI_EN
    return lo_addr(s, e) + 20'd1;
`else
    return {s, 4'h0} + {4'h0, e1};
`endif
  endfunction

  // Called just after a falling edge; the values are sampled at the next
  // rising edge, which will be numbered cyc+1.
  task automatic drive_cycle(input logic st, input logic rst, input logic [15:0] s,
                             input logic [15:0] e, input logic [15:0] r, input logic b);
    int a;
    bus.start  = st;
    reset      = rst;
    bus.seg    = s;
    bus.eff    = e;
    bus.result = r;
    bus.bit16  = b;
    a = cyc + 1;
    if (rst) begin
      while (wr_q.size() > 0 && wr_q[$].cyc >= a) void'(wr_q.pop_back());
      while (done_q.size() > 0 && done_q[$] >= a) void'(done_q.pop_back());
      idle_from = a + 1;
    end else if (st && a >= idle_from) begin
      wr_q.push_back('{a, lo_addr(s, e), r[7:0]});
      if (b) begin
        wr_q.push_back('{a + 1, hi_addr(s, e), r[15:8]});
        done_q.push_back(a + 2);
        idle_from = a + 4;
      end else begin
        done_q.push_back(a + 1);
        idle_from = a + 3;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  // Monitor: compares every cycle against the scoreboard.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
        wr_t w;
        w = wr_q.pop_front();
        check_eq("wren", 32'(bus.wren), 32'd1);
        check_eq("address", 32'(bus.address), 32'(w.addr));
        check_eq("out", 32'(bus.out), 32'(w.data));
        check_eq("busy_wr", 32'(bus.busy), 32'd1);
      end else begin
        check_eq("wren_idle", 32'(bus.wren), 32'd0);
        check_eq("busy_idle", 32'(bus.busy), 32'd0);
        check_eq("bus_zero", {4'h0, bus.address, bus.out}, 32'd0);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        check_eq("done", 32'(bus.done), 32'd1);
      end else begin
        check_eq("done_idle", 32'(bus.done), 32'd0);
      end
    end
  end

  initial begin
    bus.start  = 1'b0;
    bus.bit16  = 1'b0;
    bus.seg    = '0;
    bus.eff    = '0;
    bus.result = '0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
    check_eq("rst_wren", 32'(bus.wren), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_addr", 32'(bus.address), 32'd0);
    check_eq("rst_out", 32'(bus.out), 32'd0);
    idle(2);

    // byte write
    drive_cycle(1'b1, 1'b0, 16'h1000, 16'h0234, 16'h12AB, 1'b0);
    idle(4);
    // word write
    drive_cycle(1'b1, 1'b0, 16'h2000, 16'h0010, 16'hBEEF, 1'b1);
    idle(5);
    // offset wrap inside the segment (or linear carry with the option)
    drive_cycle(1'b1, 1'b0, 16'h3000, 16'hFFFF, 16'h1234, 1'b1);
    idle(5);
    // 1 MiB wrap
    drive_cycle(1'b1, 1'b0, 16'hFFFF, 16'h0010, 16'h5A5A, 1'b0);
    idle(4);
    // 1 MiB wrap on the high byte
    drive_cycle(1'b1, 1'b0, 16'hFFFF, 16'h000F, 16'h9C3E, 1'b1);
    idle(5);

    // reset while the low byte is on the bus aborts the transfer
    drive_cycle(1'b1, 1'b0, 16'h4000, 16'h0100, 16'hCAFE, 1'b1);
    drive_cycle(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
    idle(5);
    // reset wins over a coincident start
    drive_cycle(1'b1, 1'b1, 16'h5000, 16'h0001, 16'h7788, 1'b1);
    idle(4);

    // starts while busy are dropped; start four cycles later is taken
    drive_cycle(1'b1, 1'b0, 16'h6000, 16'h0002, 16'hA1B2, 1'b1);
    drive_cycle(1'b1, 1'b0, 16'h7000, 16'h0004, 16'h1111, 1'b0);
    drive_cycle(1'b1, 1'b0, 16'h7100, 16'h0005, 16'h2222, 1'b1);
    drive_cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    drive_cycle(1'b1, 1'b0, 16'h8000, 16'h0003, 16'hC3D4, 1'b0);
    idle(4);

    // start held high: only every third cycle is accepted for byte writes
    for (int i = 0; i < 7; i++)
      drive_cycle(1'b1, 1'b0, 16'h9000 + 16'(i), 16'h0100 + 16'(i), 16'h4400 + 16'(i), 1'b0);
    idle(4);

    // random traffic with occasional reset
    for (int i = 0; i < 80; i++)
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0,
                  16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
